// File: rtl/scaler_pll_lock_sequencer_if.sv
// Sequencer-side bundle for the scaler video PLL reset/lock sequencer.
// master = sequencer, slave = PLL wrapper / downstream consumer.
interface scaler_pll_lock_sequencer_if;
    logic       restart;
    logic       pll_locked;
    logic       pll_rst;
    logic       video_rst;
    logic       ready;
    logic       fail;
    logic       lost_lock;
    logic [7:0] retry_count;
    logic [2:0] state;

    modport master (
        input  restart, pll_locked,
        output pll_rst, video_rst, ready, fail, lost_lock, retry_count, state
    );

    modport slave (
        output restart, pll_locked,
        input  pll_rst, video_rst, ready, fail, lost_lock, retry_count, state
    );
endinterface

// File: rtl/scaler_pll_lock_sequencer.sv
// Pulses the PLL reset, waits for a stable synchronized lock, then releases
// downstream video reset; bounded retries on timeout, restart on loss of lock.
module scaler_pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          refclk,
    input  logic                          rst,
    scaler_pll_lock_sequencer_if.master   bus
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_B);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4,
        FAIL      = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic                   lost_q, lost_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_sync;

    // pll_locked is asynchronous; only the last synchronizer stage is trusted.
    assign lock_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= PLLRST;
            cnt_q   <= '0;
            retry_q <= '0;
            lost_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        if (bus.restart) begin
            state_d = PLLRST;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            unique case (state_q)
                PLLRST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = PLLRST;
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    // A drop during qualification opens a fresh window without
                    // charging a retry.
                    if (!lock_sync) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_sync) state_d = LOST;
                end
                LOST: begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                    retry_d = '0;
                    lost_d  = 1'b1;
                end
                FAIL: state_d = FAIL;
                default: begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pll_rst     = (state_q == PLLRST) || (state_q == FAIL);
        bus.ready       = (state_q == RUN);
        bus.video_rst   = (state_q != RUN);
        bus.fail        = (state_q == FAIL);
        bus.lost_lock   = lost_q;
        bus.retry_count = retry_q;
        bus.state       = state_q;
    end

endmodule
